// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and byte width for the SPI request arbiter
package spi_pkg;

  localparam int SPI_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARB   = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_XFER  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set req bit at or after ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] sel,
  output logic [PW-1:0]   idx
);

  // One spare bit so ptr+k can exceed NREQ-1 before the wrap is subtracted.
  logic [PW:0] w_j;
  logic        w_found;

  always_comb begin
    sel     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = {1'b0, ptr} + (PW+1)'(k);
      if (w_j >= (PW+1)'(NREQ)) w_j = w_j - (PW+1)'(NREQ);
      if (!w_found && req[w_j[PW-1:0]]) begin
        w_found            = 1'b1;
        sel[w_j[PW-1:0]]   = 1'b1;
        idx                = w_j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// rtl/spi_req_arbiter.sv - round-robin sharing of one spi_master among NREQ requesters
// Optional XFER watchdog with err output: define SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int SETUP_CYC = 2
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [SPI_W*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]       req_cpol,
  input  logic [NREQ-1:0]       req_cpha,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [SPI_W-1:0]      rd_data,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic                  err,
`endif
  output logic [SPI_W-1:0]      m_datain,
  output logic                  m_write,
  output logic                  m_read,
  output logic                  m_cpol,
  output logic                  m_cpha,
  input  logic                  m_done,
  input  logic [SPI_W-1:0]      m_rdata
);

  localparam int PW = $clog2(NREQ);

  logic [2:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gidx;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [SPI_W-1:0] r_rdata;
  logic [SPI_W-1:0] r_datain;
  logic             r_wr;
  logic             r_write;
  logic             r_read;
  logic             r_cpol;
  logic             r_cpha;
  logic [15:0]      r_cnt;
  logic [NREQ-1:0]  w_sel;
  logic [PW-1:0]    w_idx;

`ifdef SPI_ARB_TIMEOUT_EN
  // Leave XFER one edge early so done/err land TIMEOUT_CYC edges after XFER entry.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 2);
  logic r_to;
  logic r_err;
  assign err = r_err;
`endif

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (r_ptr),
    .sel (w_sel),
    .idx (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gidx   <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_datain <= '0;
      r_wr     <= 1'b0;
      r_write  <= 1'b0;
      r_read   <= 1'b0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_cnt    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_to     <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: if (|req) r_state <= ST_ARB;
        ST_ARB: begin
          if (|req) begin
            r_gnt    <= w_sel;
            r_gidx   <= w_idx;
            r_wr     <= req_wr[w_idx];
            r_cpol   <= req_cpol[w_idx];
            r_cpha   <= req_cpha[w_idx];
            r_datain <= req_data[w_idx*SPI_W +: SPI_W];
            r_cnt    <= '0;
            r_state  <= ST_SETUP;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (r_cnt == 16'(SETUP_CYC - 1)) begin
            r_cnt   <= '0;
            r_write <= r_wr;
            r_read  <= ~r_wr;
            r_state <= ST_XFER;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        ST_XFER: begin
          if (m_done) begin
            if (!r_wr) r_rdata <= m_rdata;
            r_state <= ST_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
          end else if (r_cnt == TO_LAST) begin
            r_to    <= 1'b1;
            r_state <= ST_DONE;
`endif
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          r_done  <= r_gnt;
          r_gnt   <= '0;
          r_write <= 1'b0;
          r_read  <= 1'b0;
          r_ptr   <= (r_gidx == PW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          r_err   <= r_to;
          r_to    <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Mode and data stay registered after DONE so SCLK idles at the last used polarity.
  assign gnt      = r_gnt;
  assign done     = r_done;
  assign rd_data  = r_rdata;
  assign m_datain = r_datain;
  assign m_write  = r_write;
  assign m_read   = r_read;
  assign m_cpol   = r_cpol;
  assign m_cpha   = r_cpha;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb/tb_spi_req_arbiter.sv - table-driven bench for spi_req_arbiter (NREQ=4, SETUP_CYC=2)
module tb_spi_req_arbiter;

  localparam int NREQ      = 4;
  localparam int SETUP_CYC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_wr, req_cpol, req_cpha;
  logic [31:0] req_data;
  logic [3:0]  gnt, done;
  logic [7:0]  rd_data, m_datain, m_rdata;
  logic        m_write, m_read, m_cpol, m_cpha, m_done;
`ifdef SPI_ARB_TIMEOUT_EN
  logic        err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_req_arbiter #(
    .NREQ(NREQ),
    .SETUP_CYC(SETUP_CYC)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_wr(req_wr), .req_data(req_data),
    .req_cpol(req_cpol), .req_cpha(req_cpha),
    .gnt(gnt), .done(done), .rd_data(rd_data),
`ifdef SPI_ARB_TIMEOUT_EN
    .err(err),
`endif
    .m_datain(m_datain), .m_write(m_write), .m_read(m_read),
    .m_cpol(m_cpol), .m_cpha(m_cpha),
    .m_done(m_done), .m_rdata(m_rdata)
  );

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  wr;
    logic [31:0] data;
    logic [3:0]  cpol;
    logic [3:0]  cpha;
    logic [7:0]  mrd;
    logic        keep;
    logic [3:0]  lat;
    logic [3:0]  e_gnt;
    logic [7:0]  e_dat;
    logic        e_wr;
    logic        e_cpol;
    logic        e_cpha;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    req_wr = v.wr; req_data = v.data; req_cpol = v.cpol; req_cpha = v.cpha; req = v.req;
    n = 0;
    while (gnt == 4'd0 && n < 10) begin @(negedge clk); n++; end
    chk("grant_latency", n, 32'(v.lat));
    chk("gnt", gnt, v.e_gnt);
    chk("m_cpol", m_cpol, v.e_cpol);
    chk("m_cpha", m_cpha, v.e_cpha);
    chk("m_datain", m_datain, v.e_dat);
    chk("strobe_in_setup", {m_write, m_read}, 0);
    // Requester inputs must be ignored once granted.
    req_wr = ~v.wr; req_data = ~v.data; req_cpol = ~v.cpol; req_cpha = ~v.cpha;
    if (!v.keep) req = 4'd0;
    n = 0;
    while (!(m_write | m_read) && n < 20) begin @(negedge clk); n++; end
    chk("setup_cycles", n, SETUP_CYC);
    chk("strobe_dir", {m_write, m_read}, {v.e_wr, ~v.e_wr});
    repeat (2) begin
      @(negedge clk);
      chk("strobe_held", {m_write, m_read}, {v.e_wr, ~v.e_wr});
      chk("done_early", done, 0);
    end
    m_done = 1'b1; m_rdata = v.mrd;
    @(negedge clk);
    m_done = 1'b0; m_rdata = 8'h00;
    chk("done_lag", done, 0);
    chk("strobe_until_done", {m_write, m_read}, {v.e_wr, ~v.e_wr});
    @(negedge clk);
    chk("done", done, v.e_gnt);
    chk("rd_data", rd_data, v.e_rd);
    chk("gnt_clear", gnt, 0);
    chk("strobe_drop", {m_write, m_read}, 0);
    chk("m_datain_hold", m_datain, v.e_dat);
    chk("m_cpol_idle", m_cpol, v.e_cpol);
    if (!v.keep) req = 4'd0;
    @(negedge clk);
    chk("done_pulse_len", done, 0);
  endtask

  initial begin
    int n;
    //          req     wr      data          cpol    cpha    mrd    keep  lat  e_gnt   e_dat  wr    cpol  cpha  e_rd
    vt[0] = '{4'b0001, 4'b0001, 32'h000000A5, 4'b0000, 4'b0000, 8'h00, 1'b0, 4'd2, 4'b0001, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[1] = '{4'b0100, 4'b0000, 32'h005A0000, 4'b0000, 4'b0000, 8'h3C, 1'b0, 4'd2, 4'b0100, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[2] = '{4'b0010, 4'b0010, 32'h00007700, 4'b0010, 4'b0010, 8'hEE, 1'b0, 4'd2, 4'b0010, 8'h77, 1'b1, 1'b1, 1'b1, 8'h3C};
    vt[3] = '{4'b0001, 4'b0000, 32'h000000C0, 4'b0000, 4'b0000, 8'h96, 1'b0, 4'd2, 4'b0001, 8'hC0, 1'b0, 1'b0, 1'b0, 8'h96};
    vt[4] = '{4'b1001, 4'b1000, 32'hBB0000DD, 4'b1000, 4'b0000, 8'h11, 1'b0, 4'd2, 4'b1000, 8'hBB, 1'b1, 1'b1, 1'b0, 8'h96};
    vt[5] = '{4'b1111, 4'b0101, 32'h44332211, 4'b1010, 4'b1100, 8'h55, 1'b1, 4'd2, 4'b0001, 8'h11, 1'b1, 1'b0, 1'b0, 8'h96};
    vt[6] = '{4'b1111, 4'b0101, 32'h44332211, 4'b1010, 4'b1100, 8'h81, 1'b1, 4'd1, 4'b0010, 8'h22, 1'b0, 1'b1, 1'b0, 8'h81};
    vt[7] = '{4'b1111, 4'b0101, 32'h44332211, 4'b1010, 4'b1100, 8'h5F, 1'b1, 4'd1, 4'b0100, 8'h33, 1'b1, 1'b0, 1'b1, 8'h81};
    vt[8] = '{4'b1111, 4'b0101, 32'h44332211, 4'b1010, 4'b1100, 8'hC3, 1'b1, 4'd1, 4'b1000, 8'h44, 1'b0, 1'b1, 1'b1, 8'hC3};
    vt[9] = '{4'b1111, 4'b0101, 32'h44332211, 4'b1010, 4'b1100, 8'h99, 1'b0, 4'd1, 4'b0001, 8'h11, 1'b1, 1'b0, 1'b0, 8'hC3};

    reset = 1'b1; req = '0; req_wr = '0; req_data = '0; req_cpol = '0; req_cpha = '0;
    m_done = 1'b0; m_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {gnt, done, rd_data, m_datain, m_write, m_read, m_cpol, m_cpha}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Reset in the middle of a read transfer.
    req = 4'b0010; req_wr = 4'b0000; req_data = 32'h00007E00; req_cpol = 4'b0010; req_cpha = 4'b0000;
    n = 0;
    while (gnt == 4'd0 && n < 10) begin @(negedge clk); n++; end
    req = 4'd0;
    n = 0;
    while (!m_read && n < 20) begin @(negedge clk); n++; end
    chk("mid_xfer_reached", m_read, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_xfer", {gnt, done, rd_data, m_datain, m_write, m_read, m_cpol, m_cpha}, 0);
    reset = 1'b0;
    repeat (3) begin @(negedge clk); chk("no_done_after_reset", done, 0); end

    // Stray m_done while idle must not move rd_data.
    m_done = 1'b1; m_rdata = 8'hFF;
    @(negedge clk);
    m_done = 1'b0; m_rdata = 8'h00;
    @(negedge clk);
    chk("idle_m_done_rd", rd_data, 0);
    chk("idle_m_done_done", done, 0);

    // ptr was cleared by reset, so all-requesting picks requester 0.
    req = 4'b1111; req_wr = 4'b1111;
    n = 0;
    while (gnt == 4'd0 && n < 10) begin @(negedge clk); n++; end
    chk("ptr_after_reset", gnt, 4'b0001);
    req = 4'd0;

`ifdef SPI_ARB_TIMEOUT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0001; req_wr = 4'b0001;
    n = 0;
    while (gnt == 4'd0 && n < 10) begin @(negedge clk); n++; end
    req = 4'd0;
    n = 0;
    while (!m_write && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (done == 4'd0 && n < 40) begin @(negedge clk); n++; end
    chk("timeout_cycles", n, 16);
    chk("timeout_done", done, 4'b0001);
    chk("timeout_err", err, 1);
    chk("timeout_strobe", {m_write, m_read}, 0);
    chk("timeout_rd", rd_data, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
